// File: rtl/cr_xp10_decomp_fe_crc_mc.sv
// cr_xp10_decomp_fe_crc_mc: multi-channel streaming CRC32C engine.
// Ports: clk/rst (sync, active-high); in_* beat bus with valid/ready,
// channel, sof/eof, data, byte count and expected CRC; out_* registered
// per-frame result (channel, CRC, match, error) with valid/ready;
// ch_active per-channel frame-in-progress flags.
module cr_xp10_decomp_fe_crc_mc #(
    parameter int          DATA_W  = 64,
    parameter int          NUM_CH  = 4,
    parameter logic [31:0] POLY    = 32'h82f63b78,
    parameter logic [31:0] INIT    = 32'hffff_ffff,
    parameter logic [31:0] XOR_OUT = 32'hffff_ffff,
    localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         NB      = DATA_W / 8,
    localparam int         NB_W    = $clog2(NB) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NB_W-1:0]   in_nbytes,
    input  logic [31:0]       in_exp_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [31:0]       out_crc,
    output logic              out_match,
    output logic              out_err,
    output logic [NUM_CH-1:0] ch_active
);

    localparam logic [NB_W-1:0] NB_MAX = NB_W'(NB);

    logic [31:0]       acc [NUM_CH];
    logic [NUM_CH-1:0] err_q;

    logic              in_fire;
    logic [31:0]       acc_sel;
    logic              act_sel;
    logic              err_sel;
    logic              nb_over;
    logic [NB_W-1:0]   nb_eff;
    logic              beat_err;
    logic              use_init;
    logic [31:0]       seed;
    logic [31:0]       crc_next;
    logic [31:0]       crc_final;

    // Single output register: a new beat may only be taken if the slot is
    // empty or is being drained on this same edge.
    assign in_ready = ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;

    // Per-channel state selected by the incoming channel number.
    always_comb begin
        acc_sel = INIT;
        act_sel = 1'b0;
        err_sel = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == in_ch) begin
                acc_sel = acc[c];
                act_sel = ch_active[c];
                err_sel = err_q[c];
            end
        end
    end

    assign nb_over  = in_nbytes > NB_MAX;
    assign nb_eff   = nb_over ? NB_MAX : in_nbytes;

    // A missing sof on an idle channel acts as an implicit sof; a sof on
    // a busy channel drops the old frame. Both are flagged.
    assign beat_err = nb_over
                    | (~in_sof & ~act_sel)
                    | ( in_sof &  act_sel);
    assign use_init = in_sof | ~act_sel;
    assign seed     = use_init ? INIT : acc_sel;

    // Reflected bitwise CRC over the first nb_eff bytes, byte 0 first.
    always_comb begin
        crc_next = seed;
        for (int i = 0; i < NB; i++) begin
            if (NB_W'(i) < nb_eff) begin
                crc_next = crc_next ^ {24'd0, in_data[i*8 +: 8]};
                for (int b = 0; b < 8; b++) begin
                    if (crc_next[0]) begin
                        crc_next = (crc_next >> 1) ^ POLY;
                    end else begin
                        crc_next = crc_next >> 1;
                    end
                end
            end
        end
    end

    assign crc_final = crc_next ^ XOR_OUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= INIT;
            end
            err_q     <= '0;
            ch_active <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_crc   <= '0;
            out_match <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_fire) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (CH_W'(c) == in_ch) begin
                        if (in_eof) begin
                            acc[c]       <= INIT;
                            ch_active[c] <= 1'b0;
                            err_q[c]     <= 1'b0;
                        end else begin
                            acc[c]       <= crc_next;
                            ch_active[c] <= 1'b1;
                            err_q[c]     <= err_sel | beat_err;
                        end
                    end
                end
                // Loading here also covers the drain-and-refill case,
                // since this assignment overrides the clear above.
                if (in_eof) begin
                    out_valid <= 1'b1;
                    out_ch    <= in_ch;
                    out_crc   <= crc_final;
                    out_match <= (crc_final == in_exp_crc);
                    out_err   <= err_sel | beat_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_cr_xp10_decomp_fe_crc_mc.sv
// tb_cr_xp10_decomp_fe_crc_mc: directed bench for the CRC32C engine.
// Drives beats after each edge and samples outputs 1 time unit later.
module tb_cr_xp10_decomp_fe_crc_mc;

    localparam logic [31:0] CHK = 32'hE3069283;
    localparam logic [63:0] D8  = 64'h3837363534333231;
    localparam logic [63:0] D9  = 64'h39;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic        in_sof;
    logic        in_eof;
    logic [63:0] in_data;
    logic [3:0]  in_nbytes;
    logic [31:0] in_exp_crc;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [31:0] out_crc;
    logic        out_match;
    logic        out_err;
    logic [3:0]  ch_active;

    int vectors;
    int miscompares;

    cr_xp10_decomp_fe_crc_mc dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_sof     (in_sof),
        .in_eof     (in_eof),
        .in_data    (in_data),
        .in_nbytes  (in_nbytes),
        .in_exp_crc (in_exp_crc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_crc    (out_crc),
        .out_match  (out_match),
        .out_err    (out_err),
        .ch_active  (ch_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [1:0] ch, input logic sof,
                             input logic eof, input logic [63:0] d,
                             input logic [3:0] nb, input logic [31:0] exp);
        int k;
        in_valid   = 1'b1;
        in_ch      = ch;
        in_sof     = sof;
        in_eof     = eof;
        in_data    = d;
        in_nbytes  = nb;
        in_exp_crc = exp;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout ch=%0d got in_ready=%b want 1",
                     ch, in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vectors++;
        if (ch_active !== 4'b0) begin miscompares++; $display("FAIL rst_ch_active got %b want 0000", ch_active); end
        vectors++;
        if (out_crc !== 32'h0) begin miscompares++; $display("FAIL rst_out_crc got %h want 00000000", out_crc); end
        vectors++;
        if ({out_ch, out_match, out_err} !== 4'b0) begin miscompares++; $display("FAIL rst_out_misc got %b want 0000", {out_ch, out_match, out_err}); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single_frame();
        send_beat(2'd0, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        vectors++;
        if (ch_active !== 4'b0001) begin miscompares++; $display("FAIL single_active got %b want 0001", ch_active); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        send_beat(2'd0, 1'b0, 1'b1, D9, 4'd1, CHK);
        vectors++;
        if ({out_valid, out_ch} !== 3'b100) begin miscompares++; $display("FAIL single_valid_ch got %b want 100", {out_valid, out_ch}); end
        vectors++;
        if (out_crc !== CHK) begin miscompares++; $display("FAIL single_crc got %h want %h", out_crc, CHK); end
        vectors++;
        if ({out_match, out_err} !== 2'b10) begin miscompares++; $display("FAIL single_match_err got %b want 10", {out_match, out_err}); end
        vectors++;
        if (ch_active !== 4'b0) begin miscompares++; $display("FAIL single_active_clr got %b want 0000", ch_active); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_interleave();
        send_beat(2'd2, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        send_beat(2'd1, 1'b1, 1'b0, 64'hdeadbeef_34333231, 4'd4, 32'h0);
        vectors++;
        if (ch_active !== 4'b0110) begin miscompares++; $display("FAIL ilv_active got %b want 0110", ch_active); end
        send_beat(2'd2, 1'b0, 1'b1, D9, 4'd1, CHK);
        vectors++;
        if ({out_valid, out_ch} !== 3'b110) begin miscompares++; $display("FAIL ilv_ch2 got %b want 110", {out_valid, out_ch}); end
        vectors++;
        if (out_crc !== CHK) begin miscompares++; $display("FAIL ilv_crc2 got %h want %h", out_crc, CHK); end
        vectors++;
        if (ch_active !== 4'b0010) begin miscompares++; $display("FAIL ilv_active2 got %b want 0010", ch_active); end
        send_beat(2'd1, 1'b0, 1'b1, 64'hffffff39_38373635, 4'd5, CHK);
        vectors++;
        if ({out_valid, out_ch} !== 3'b101) begin miscompares++; $display("FAIL ilv_ch1 got %b want 101", {out_valid, out_ch}); end
        vectors++;
        if ({out_crc, out_match, out_err} !== {CHK, 2'b10}) begin miscompares++; $display("FAIL ilv_crc1 got %h/%b%b want %h/10", out_crc, out_match, out_err, CHK); end
        vectors++;
        if (ch_active !== 4'b0) begin miscompares++; $display("FAIL ilv_active1 got %b want 0000", ch_active); end
        tick();
    endtask

    task automatic test_empty_and_mismatch();
        send_beat(2'd0, 1'b1, 1'b1, 64'h1234, 4'd0, 32'h0);
        vectors++;
        if ({out_valid, out_crc} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL empty_crc got %b/%h want 1/00000000", out_valid, out_crc); end
        vectors++;
        if ({out_match, out_err} !== 2'b10) begin miscompares++; $display("FAIL empty_match got %b want 10", {out_match, out_err}); end
        send_beat(2'd0, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        send_beat(2'd0, 1'b0, 1'b1, D9, 4'd1, 32'hE3069284);
        vectors++;
        if ({out_valid, out_crc} !== {1'b1, CHK}) begin miscompares++; $display("FAIL badexp_crc got %b/%h want 1/%h", out_valid, out_crc, CHK); end
        vectors++;
        if (out_match !== 1'b0) begin miscompares++; $display("FAIL badexp_match got %b want 0", out_match); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_beat(2'd0, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        send_beat(2'd0, 1'b0, 1'b1, D9, 4'd1, CHK);
        in_valid   = 1'b1;
        in_ch      = 2'd1;
        in_sof     = 1'b1;
        in_eof     = 1'b1;
        in_data    = 64'h0;
        in_nbytes  = 4'd0;
        in_exp_crc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready cyc=%0d got %b want 0", i, in_ready); end
            vectors++;
            if ({out_valid, out_ch, out_crc, out_match, out_err} !== {3'b100, CHK, 2'b10}) begin
                miscompares++;
                $display("FAIL hold_out cyc=%0d got %b/%0d/%h/%b%b want 1/0/%h/10", i, out_valid, out_ch, out_crc, out_match, out_err, CHK);
            end
            tick();
        end
        vectors++;
        if (ch_active !== 4'b0) begin miscompares++; $display("FAIL hold_no_accept got %b want 0000", ch_active); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        vectors++;
        if ({out_valid, out_ch, out_crc} !== {3'b101, 32'h0}) begin miscompares++; $display("FAIL b2b_result got %b/%0d/%h want 1/1/00000000", out_valid, out_ch, out_crc); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_protocol_errors();
        send_beat(2'd3, 1'b0, 1'b0, D8, 4'd8, 32'h0);
        vectors++;
        if (ch_active !== 4'b1000) begin miscompares++; $display("FAIL nosof_active got %b want 1000", ch_active); end
        send_beat(2'd3, 1'b0, 1'b1, D9, 4'd1, CHK);
        vectors++;
        if ({out_valid, out_ch, out_crc, out_match, out_err} !== {3'b111, CHK, 2'b11}) begin
            miscompares++;
            $display("FAIL nosof_result got %b/%0d/%h/%b%b want 1/3/%h/11", out_valid, out_ch, out_crc, out_match, out_err, CHK);
        end
        send_beat(2'd0, 1'b1, 1'b0, 64'h1122334455667788, 4'd8, 32'h0);
        send_beat(2'd0, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        send_beat(2'd0, 1'b0, 1'b1, D9, 4'd1, CHK);
        vectors++;
        if ({out_valid, out_ch, out_crc, out_match, out_err} !== {3'b100, CHK, 2'b11}) begin
            miscompares++;
            $display("FAIL resof_result got %b/%0d/%h/%b%b want 1/0/%h/11", out_valid, out_ch, out_crc, out_match, out_err, CHK);
        end
        send_beat(2'd1, 1'b1, 1'b0, D8, 4'd9, 32'h0);
        send_beat(2'd1, 1'b0, 1'b1, D9, 4'd1, CHK);
        vectors++;
        if ({out_valid, out_ch, out_crc, out_err} !== {3'b101, CHK, 1'b1}) begin
            miscompares++;
            $display("FAIL clamp_result got %b/%0d/%h/%b want 1/1/%h/1", out_valid, out_ch, out_crc, out_err, CHK);
        end
        send_beat(2'd1, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        send_beat(2'd1, 1'b0, 1'b1, D9, 4'd1, CHK);
        vectors++;
        if ({out_crc, out_err} !== {CHK, 1'b0}) begin miscompares++; $display("FAIL err_cleared got %h/%b want %h/0", out_crc, out_err, CHK); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_beat(2'd0, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        send_beat(2'd2, 1'b1, 1'b1, 64'h0, 4'd0, 32'h0);
        vectors++;
        if ({out_valid, ch_active} !== 5'b10001) begin miscompares++; $display("FAIL pre_rst got %b want 10001", {out_valid, ch_active}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({out_valid, ch_active} !== 5'b0) begin miscompares++; $display("FAIL mid_rst got %b want 00000", {out_valid, ch_active}); end
        out_ready = 1'b1;
        send_beat(2'd0, 1'b1, 1'b0, D8, 4'd8, 32'h0);
        send_beat(2'd0, 1'b0, 1'b1, D9, 4'd1, CHK);
        vectors++;
        if ({out_valid, out_ch, out_crc, out_match, out_err} !== {3'b100, CHK, 2'b10}) begin
            miscompares++;
            $display("FAIL post_rst got %b/%0d/%h/%b%b want 1/0/%h/10", out_valid, out_ch, out_crc, out_match, out_err, CHK);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_ch       = 2'd0;
        in_sof      = 1'b0;
        in_eof      = 1'b0;
        in_data     = 64'h0;
        in_nbytes   = 4'd0;
        in_exp_crc  = 32'h0;
        out_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_single_frame();
        test_interleave();
        test_empty_and_mismatch();
        test_back_to_back();
        test_protocol_errors();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cr_xp10_decomp_fe_crc_mc.md
Name: cr_xp10_decomp_fe_crc_mc

Overview:
Multi-channel streaming CRC32C engine for the decompressor front end. It accumulates a per-channel running CRC over interleaved frames carried on a single beat bus and emits one registered final CRC per frame at end-of-frame. At end-of-frame it also compares the result against an expected CRC supplied with the eof beat. It replaces the per-beat combinational CRC step: CRC state is now held internally per channel, with a valid/ready handshake on input and output.

Parameters:
DATA_W, 64, beat width in bits; multiple of 8, range 8..256.
NUM_CH, 4, number of independent channels; range 1..16.
POLY, 32'h82f63b78, reflected CRC polynomial (CRC32C).
INIT, 32'hffff_ffff, accumulator value loaded at sof.
XOR_OUT, 32'hffff_ffff, value XORed into the accumulator to form out_crc.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_ch  in  max(1,$clog2(NUM_CH))  channel of beat
in_sof  in  1  first beat of frame
in_eof  in  1  last beat of frame
in_data  in  DATA_W  beat data; byte 0 = in_data[7:0], processed first
in_nbytes  in  $clog2(DATA_W/8)+1  valid bytes in beat, LSB-aligned
in_exp_crc  in  32  expected final CRC; sampled only on accepted eof beat
out_valid  out  1  frame result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_ch  out  max(1,$clog2(NUM_CH))  channel of result
out_crc  out  32  final CRC (accumulator ^ XOR_OUT)
out_match  out  1  out_crc == sampled in_exp_crc
out_err  out  1  protocol error seen in this frame
ch_active  out  NUM_CH  per-channel frame-in-progress flags

Behaviour:
- Reset (rst=1 at a clk edge): all acc[ch]=INIT, ch_active=0, per-channel err=0, out_valid=0, out_ch=0, out_crc=0, out_match=0, out_err=0. Reset mid-frame discards all partial frames and any unconsumed result; no result is emitted.
- in_ready = ~out_valid | out_ready. The output holds a single registered result; no other buffering.
- Accepted beat: seed = in_sof ? INIT : acc[in_ch]. Fold bytes 0..n-1 into the seed with the reflected bitwise CRC (shift right, XOR POLY when the shifted-out bit is 1).
  - n = min(in_nbytes, DATA_W/8); oversize counts clamp and set err.
  - n=0 leaves the CRC unchanged; this is legal, including on sof or eof beats.
- Non-eof accepted beat: acc[in_ch] <= new CRC; ch_active[in_ch] <= 1.
- Eof accepted beat (including sof&eof on the same beat):
  - Next cycle: out_valid=1, out_ch=in_ch, out_crc=new^XOR_OUT, out_match=(out_crc==in_exp_crc), out_err=err[in_ch] | error of this beat.
  - acc[in_ch] <= INIT; ch_active[in_ch] <= 0; err[in_ch] <= 0.
  - Latency: eof accept to out_valid = 1 cycle.
- Protocol errors (sticky per channel until that channel's eof):
  - Beat without sof on an inactive channel: treated as an implicit sof (seed INIT); set err.
  - sof on an active channel: restart from INIT, discarding the old frame; set err.
  - Clamped in_nbytes: set err.
- out_valid & ~out_ready: all out_* signals hold stable; in_ready=0, so no beat is accepted on any channel.
- out_valid & out_ready with a simultaneous eof accept: new result loads on the same edge, giving back-to-back results with no bubble.
- Channels are fully independent; interleaving at beat granularity is legal.
- Folding is combinational within the beat cycle; the only state is acc[], ch_active, err[] and the output register.

Test Plan:
- Single frame ch0: beat1 data=64'h3837363534333231 nbytes=8 sof; beat2 data=64'h39 nbytes=1 eof exp=32'hE3069283 -> 1 cycle later out_valid, out_ch=0, out_crc=32'hE3069283, out_match=1, out_err=0.
- Same frame on ch2, beats interleaved with a "123456789" frame on ch1 -> two results, both 32'hE3069283, each with its own out_ch; ch_active clears per channel at its eof.
- Single beat sof&eof, nbytes=0 -> out_crc=32'h00000000; with exp=0 -> out_match=1. Wrong exp on the first scenario (32'hE3069284) -> out_match=0.
- Hold out_ready=0 on a pending result while in_valid=1 -> in_ready=0 and out_* stable for 10 cycles; assert out_ready -> next eof result appears with no bubble.
- Mid-frame beat without sof on idle ch3, and sof on an active channel -> frames complete with out_err=1; nbytes=9 (DATA_W=64) clamps to 8 and sets out_err=1.
- rst=1 for one cycle mid-frame on ch0 -> ch_active=0, out_valid=0; a following full "123456789" frame yields 32'hE3069283 with out_err=0.
